uart_mem_bridge: RTL
====================

Name: uart_mem_bridge

Overview:
- Parametrised next-generation serial memory bridge between the CPU data bus and a host link.
- Latches a bus request and serialises it as a command frame to a byte-wide UART transmitter. For reads and optionally acknowledged writes, it collects the host response from a byte-wide UART receiver.
- Adds three things the previous bridge lacked: configurable address/data widths, write acknowledgement, and response timeout with bounded retry and error reporting.

Parameters:
- ADDR_W, 32, bus address width; multiple of 8, range 8..32.
- DATA_W, 32, bus data width; multiple of 8, range 8..64.
- ACK_WRITES, 1, when 1, memory writes wait for a host ack byte.
- ACK_BYTE, 8'hA5, required ack value.
- TIMEOUT_CYCLES, 250000, maximum clk cycles allowed after the last TX byte and between RX bytes; minimum 2.
- MAX_RETRY, 2, number of frame resends after a timeout before an error is reported.
- IO_ADDR_HLT, 0, IO address that issues HLT.
- IO_ADDR_PRINT, 1, IO address that issues PRINT.

Ports:
- clk  in  1  clock
- res  in  1  reset, asynchronous, active-low
- db_addr  in  ADDR_W  bus address
- db_dataOut  in  DATA_W  write data
- db_re  in  1  read request
- db_we  in  1  write request
- db_io  in  1  IO-space qualifier
- db_dataIn  out  DATA_W  read data, held until the next read completes
- db_ready  out  1  bridge idle; a request is accepted this cycle
- db_err  out  1  last transaction timed out after all retries; sticky until the next accept
- tx_byte  out  8  byte to the UART TX
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  UART TX accepts a byte when tx_valid && tx_ready
- rx_byte  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid

Behaviour:
- Reset (res low, asynchronous): state IDLE, db_ready=1, db_err=0, db_dataIn=0, tx_valid=0, tx_byte=0, all counters 0. Reset mid-frame aborts immediately. Any partial frame is abandoned, and the host resynchronises on its own timeout.
- Command decode when db_ready=1:
  - db_io && db_we, addr==IO_ADDR_HLT -> HLT (0x04).
  - db_io && db_we, addr==IO_ADDR_PRINT -> PRINT (0x03).
  - Any other IO write -> ignored. No accept; db_ready stays 1.
  - !db_io && db_we -> WRITE (0x02).
  - !db_io && db_re -> READ (0x01).
  - db_re && db_we together with !db_io -> WRITE wins.
  - db_io && db_re -> ignored.
- Accept: on a cycle with db_ready=1 and a valid command, latch cmd, addr and data, clear db_err, and load retry=0. db_ready drops on the following cycle.
- Frame format: cmd byte, then fields LSB byte first.
  - READ: cmd, then ADDR_W/8 address bytes.
  - WRITE: cmd, address bytes, then DATA_W/8 data bytes.
  - PRINT: cmd, then DATA_W/8 data bytes.
  - HLT: cmd only.
- States:
  - IDLE: on accept -> SEND.
  - SEND: present the byte at index idx; advance idx on each tx_valid&&tx_ready. After the last byte: go to WAIT_RESP if READ, or if WRITE with ACK_WRITES=1; otherwise go to IDLE. tx_valid stays high, with tx_byte stable, until the handshake completes.
  - WAIT_RESP: the timer resets to 0 on entry and on every rx_valid.
    - READ: shift in DATA_W/8 bytes, LSB first. On the last byte, update db_dataIn in the same edge -> IDLE.
    - WRITE: one byte. If it equals ACK_BYTE -> IDLE. Any other value counts as a timeout event immediately.
    - Timer reaching TIMEOUT_CYCLES-1 with no rx_valid:
      - if retry<MAX_RETRY: retry+1, discard partial bytes, idx=0 -> SEND.
      - otherwise: db_err=1, db_dataIn=all ones for READ (unchanged for WRITE) -> IDLE.
    - rx_valid on the same cycle as the timeout: the byte wins and the timer resets.
  - rx_valid outside WAIT_RESP: ignored.
- Latency: for a READ with an instant tx_ready and host, db_ready returns 1 one cycle after the final rx byte.
- Counters: idx width is clog2(1+ADDR_W/8+DATA_W/8). The timer saturates at compare and never wraps. The retry counter is clog2(MAX_RETRY+1) bits wide.

Test Plan:
- Reset: hold res=0, then release -> db_ready=1, tx_valid=0, db_err=0, db_dataIn=0.
- Write, defaults: db_we, addr=0x00001000, data=0xDEADBEEF -> TX sequence 02 00 10 00 00 EF BE AD DE. Host sends A5 -> db_ready returns 1, db_err=0.
- Read: db_re, addr=0x20 -> TX sequence 01 20 00 00 00. Host sends 78 56 34 12 -> db_dataIn=0x12345678, db_ready=1 one cycle after the last strobe.
- IO print/hlt: db_io&&db_we to addr 1 with data 0x41 -> TX 03 41 00 00 00, with no wait. IO write to addr 0 -> TX 04 only. IO write to addr 7 -> no TX, db_ready stays 1.
- Timeout/retry: TIMEOUT_CYCLES=16, MAX_RETRY=2, read with no host response -> the frame is sent 3 times, then db_err=1 and db_dataIn=0xFFFFFFFF. A wrong ack byte 0x00 on a write triggers an immediate resend.
- Backpressure and reset: hold tx_ready=0 for 5 cycles mid-frame -> tx_byte stable. Assert res low mid-WAIT_RESP -> IDLE immediately; a retried frame starts clean after release. Repeat with ADDR_W=16, DATA_W=8: write frame 02 34 12 5A.

Source files
------------

// File: rtl/uart_mem_bridge_if.sv
// Purpose: bus-side and UART-side signal bundle for uart_mem_bridge.
// Latency: n/a (wires only).
// Backpressure: tx_valid/tx_ready handshake on TX; rx_valid is a one-cycle strobe with no backpressure.
// Ports: db_* CPU data bus (request in, ready/err/read data out),
//        tx_* byte stream to UART TX, rx_* byte strobe from UART RX.
interface uart_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] db_addr;
  logic [DATA_W-1:0] db_dataOut;
  logic              db_re;
  logic              db_we;
  logic              db_io;
  logic [DATA_W-1:0] db_dataIn;
  logic              db_ready;
  logic              db_err;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_byte;
  logic              rx_valid;

  // Bridge side.
  modport slave (
    input  db_addr, db_dataOut, db_re, db_we, db_io, tx_ready, rx_byte, rx_valid,
    output db_dataIn, db_ready, db_err, tx_byte, tx_valid
  );

  // CPU / UART side.
  modport master (
    output db_addr, db_dataOut, db_re, db_we, db_io, tx_ready, rx_byte, rx_valid,
    input  db_dataIn, db_ready, db_err, tx_byte, tx_valid
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// Purpose: latches a CPU bus request, sends it as a command frame over a byte UART and collects the host reply.
// Latency: frame bytes at one per tx handshake; db_ready returns one cycle after the final reply byte.
// Backpressure: tx_byte held stable while tx_ready is low; reply gaps bounded by TIMEOUT_CYCLES with retry.
// Ports: clk, res (async active-low), bus (uart_mem_bridge_if.slave: db_* bus, tx_* UART TX, rx_* UART RX).
module uart_mem_bridge #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int          ACK_WRITES     = 1,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 250000,
  parameter int          MAX_RETRY      = 2,
  parameter int          IO_ADDR_HLT    = 0,
  parameter int          IO_ADDR_PRINT  = 1
) (
  input logic              clk,
  input logic              res,
  uart_mem_bridge_if.slave bus
);

  localparam int AB = ADDR_W / 8;
  localparam int DB = DATA_W / 8;
  localparam int IW = $clog2(1 + AB + DB);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_PRINT = 8'h03;
  localparam logic [7:0] CMD_HLT   = 8'h04;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [IW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              err_q, err_d;

  // Request decode; IO writes to unknown addresses and IO reads are never accepted.
  logic       req_vld;
  logic [7:0] req_cmd;

  always_comb begin
    req_vld = 1'b0;
    req_cmd = CMD_READ;
    if (bus.db_io) begin
      if (bus.db_we && bus.db_addr == ADDR_W'(IO_ADDR_HLT)) begin
        req_vld = 1'b1;
        req_cmd = CMD_HLT;
      end else if (bus.db_we && bus.db_addr == ADDR_W'(IO_ADDR_PRINT)) begin
        req_vld = 1'b1;
        req_cmd = CMD_PRINT;
      end
    end else if (bus.db_we) begin
      req_vld = 1'b1;
      req_cmd = CMD_WRITE;
    end else if (bus.db_re) begin
      req_vld = 1'b1;
      req_cmd = CMD_READ;
    end
  end

  // Frame layout: cmd at index 0, then address bytes (READ/WRITE), then data bytes (WRITE/PRINT).
  logic              has_addr;
  logic              need_resp;
  logic [IW-1:0]     last_idx;
  logic [IW-1:0]     addr_off;
  logic [IW-1:0]     data_off;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic [7:0]        tx_byte_c;

  always_comb begin
    has_addr  = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);
    need_resp = (cmd_q == CMD_READ) || ((cmd_q == CMD_WRITE) && (ACK_WRITES != 0));
    case (cmd_q)
      CMD_READ:  last_idx = IW'(AB);
      CMD_WRITE: last_idx = IW'(AB + DB);
      CMD_PRINT: last_idx = IW'(DB);
      default:   last_idx = '0;
    endcase
    addr_off = idx_q - IW'(1);
    data_off = (cmd_q == CMD_WRITE) ? (idx_q - IW'(1) - IW'(AB)) : (idx_q - IW'(1));
    addr_sh  = addr_q >> {addr_off, 3'b000};
    data_sh  = data_q >> {data_off, 3'b000};
    tx_byte_c = 8'h00;
    if (state_q == S_SEND) begin
      if (idx_q == '0)                         tx_byte_c = cmd_q;
      else if (has_addr && idx_q <= IW'(AB))   tx_byte_c = addr_sh[7:0];
      else                                     tx_byte_c = data_sh[7:0];
    end
  end

  logic resp_fail;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    data_in_d  = data_in_q;
    err_d      = err_q;
    resp_fail  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          cmd_d   = req_cmd;
          addr_d  = bus.db_addr;
          data_d  = bus.db_dataOut;
          err_d   = 1'b0;
          retry_d = '0;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (bus.tx_ready) begin
          if (idx_q == last_idx) begin
            idx_d      = '0;
            timer_d    = '0;
            rx_cnt_d   = '0;
            rx_shift_d = '0;
            state_d    = need_resp ? S_WAIT : S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_WAIT: begin
        // A byte arriving on the timeout cycle takes priority and restarts the timer.
        if (bus.rx_valid) begin
          timer_d = '0;
          if (cmd_q == CMD_READ) begin
            rx_shift_d = rx_shift_q | (DATA_W'(bus.rx_byte) << {rx_cnt_q, 3'b000});
            if (rx_cnt_q == IW'(DB - 1)) begin
              data_in_d = rx_shift_d;
              state_d   = S_IDLE;
            end else begin
              rx_cnt_d = rx_cnt_q + IW'(1);
            end
          end else if (bus.rx_byte == ACK_BYTE) begin
            state_d = S_IDLE;
          end else begin
            resp_fail = 1'b1;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          resp_fail = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end

        if (resp_fail) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d    = retry_q + RW'(1);
            idx_d      = '0;
            rx_cnt_d   = '0;
            rx_shift_d = '0;
            state_d    = S_SEND;
          end else begin
            err_d = 1'b1;
            if (cmd_q == CMD_READ) data_in_d = '1;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      data_in_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      data_in_q  <= data_in_d;
      err_q      <= err_d;
    end
  end

  assign bus.db_ready  = (state_q == S_IDLE);
  assign bus.tx_valid  = (state_q == S_SEND);
  assign bus.tx_byte   = tx_byte_c;
  assign bus.db_dataIn = data_in_q;
  assign bus.db_err    = err_q;

endmodule
